// File: rtl/sram_pkg.sv
// Shared SRAM package: supply/threshold levels, the access-sequencer state
// encoding and the logic-to-level helper used by the row driver and by the
// decoder/array models.
package sram_pkg;

    parameter real VDD = 1.5;
    parameter real VSS = 0.0;
    parameter real VTH = 0.8;

    // One access walks IDLE -> PRE -> SETUP -> ACC -> [SENSE] -> REL -> IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SETUP = 3'd2,
        ST_ACC   = 3'd3,
        ST_SENSE = 3'd4,
        ST_REL   = 3'd5
    } acc_state_t;

    // Rail level for a logic value; only VDD or VSS is ever produced.
    function automatic real lvl(input logic b);
        return b ? VDD : VSS;
    endfunction

endpackage

// File: rtl/row_sel_driver_if.sv
// Request/completion interface between the digital controller and the row
// select driver.
//   req_valid/req_addr/req_we : request from the controller
//   req_ready                 : driver can accept a request (IDLE only)
//   done                      : one-cycle completion pulse
//   err                       : one-cycle pulse for a rejected request
interface row_sel_driver_if #(
    parameter int AW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_addr, req_we,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_we,
        output req_ready, done, err
    );
endinterface

// File: rtl/sram_lvl_drv.sv
// Logic-to-analog level converter: maps each bit of a logic vector onto a
// real rail value (VDD for 1, VSS for 0).
//   din  : logic vector, W bits
//   dout : real array [0:W-1], dout[i] = level of din[i]
module sram_lvl_drv
    import sram_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] din,
    output real          dout [0:W-1]
);

    always_comb begin
        for (int i = 0; i < W; i++) begin
            dout[i] = lvl(din[i]);
        end
    end

endmodule

// File: rtl/row_sel_driver.sv
// Row select driver: sequences one SRAM access (precharge, address setup,
// wordline, optional sense, release) per accepted request and drives the
// row code and control levels seen by the decoder and array front end.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_if      : request handshake plus done/err pulses (slave side)
//   row_sel     : real [0:AW-1], row code bits (addr+1, 0 = no row)
//   precharge   : real, bitline precharge level
//   wl_en       : real, wordline enable level
//   sae         : real, sense-amp enable level
module row_sel_driver
    import sram_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int AW      = $clog2(ROWS),
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    row_sel_driver_if.slave   req_if,
    output real               row_sel [0:AW-1],
    output real               precharge,
    output real               wl_en,
    output real               sae
);

    localparam int CNT_W = $clog2((PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC) + 1;
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYC - 1);
    // The top code is reserved: addr+1 would overflow the row code.
    localparam logic [AW-1:0]    LAST_ROW = AW'(ROWS - 1);

    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             we_q, we_d;
    logic [AW-1:0]    code_q, code_d;
    logic             ready_q, ready_d;
    logic             pre_q, pre_d;
    logic             wl_q, wl_d;
    logic             sae_q, sae_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             drive_code;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // ready_q, not the state, qualifies the handshake: the first
                // IDLE cycle after reset has req_ready low.
                if (req_if.req_valid && ready_q) begin
                    if (req_if.req_addr == LAST_ROW) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LOAD;
                        addr_d  = req_if.req_addr;
                        we_d    = req_if.req_we;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) state_d = ST_SETUP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SETUP: begin
                state_d = ST_ACC;
                cnt_d   = WL_LOAD;
            end
            ST_ACC: begin
                if (cnt_q == '0) state_d = we_q ? ST_REL : ST_SENSE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SENSE: state_d = ST_REL;
            ST_REL:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they belong to.
        drive_code = (state_d == ST_SETUP) || (state_d == ST_ACC) ||
                     (state_d == ST_SENSE);
        code_d  = drive_code ? addr_d + AW'(1) : '0;
        ready_d = (state_d == ST_IDLE);
        pre_d   = (state_d == ST_PRE);
        wl_d    = (state_d == ST_ACC);
        sae_d   = (state_d == ST_SENSE);
        done_d  = (state_d == ST_REL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            code_q  <= '0;
            ready_q <= 1'b0;
            pre_q   <= 1'b0;
            wl_q    <= 1'b0;
            sae_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            pre_q   <= pre_d;
            wl_q    <= wl_d;
            sae_q   <= sae_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_if.req_ready = ready_q;
    assign req_if.done      = done_q;
    assign req_if.err       = err_q;

    real ctl_lvl [0:2];

    sram_lvl_drv #(.W(AW)) u_row_lvl (
        .din  (code_q),
        .dout (row_sel)
    );

    // din bit i lands on dout[i]: [0]=precharge, [1]=wl_en, [2]=sae.
    sram_lvl_drv #(.W(3)) u_ctl_lvl (
        .din  ({sae_q, wl_q, pre_q}),
        .dout (ctl_lvl)
    );

    assign precharge = ctl_lvl[0];
    assign wl_en     = ctl_lvl[1];
    assign sae       = ctl_lvl[2];

endmodule

// File: doc/row_sel_driver.md
# row_sel_driver

Sequencer on the driving side of the SRAM row decoder. It accepts a digital read/write request, generates the precharge, address-setup, wordline and sense phases, and drives the real-valued `row_sel` bus and analog control levels consumed by the decoder and the array. It sits between the digital controller and the array's analog front end, one instance per array.

## Interface
Parameters:
- `ROWS`, 16: physical rows in the array.
- `AW`, `$clog2(ROWS)`: width of `row_sel` and `req_addr`.
- `PRE_CYC`, 2: precharge phase length in cycles (≥1).
- `WL_CYC`, 3: wordline-active phase length in cycles (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  AW  target row index.
- `req_we`  in  1  1 = write, 0 = read.
- `row_sel`  out  real [0:AW-1]  encoded row code to the decoder, per bit VDD/VSS.
- `precharge`  out  real  bitline precharge enable, VDD/VSS.
- `wl_en`  out  real  wordline enable, VDD/VSS.
- `sae`  out  real  sense-amp enable, VDD/VSS.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on a rejected request.

## Operation
- Row code on `row_sel` is `req_addr + 1`; code 0 means no row selected. Addressable rows are 0..ROWS-2.
- A request with `req_addr == ROWS-1` is rejected:
  - `err` pulses in the cycle after the handshake.
  - The FSM stays in IDLE, and no analog output moves.
- Logic-to-real mapping: logic 1 drives VDD = 1.5, logic 0 drives VSS = 0.0. No other values are ever driven.
- FSM states:
  - IDLE: `req_ready`=1; all real outputs VSS; `row_sel` code 0. Handshake with a valid address latches address and `we`, then goes to PRE.
  - PRE: `precharge`=VDD, code 0, for PRE_CYC cycles; then SETUP.
  - SETUP: 1 cycle; code driven and `precharge` VSS; `wl_en` VSS so the address settles first. Then ACC.
  - ACC: `wl_en`=VDD, code held, for WL_CYC cycles. Then SENSE if read, REL if write.
  - SENSE: 1 cycle; `sae`=VDD, `wl_en`=VSS, code held. Then REL.
  - REL: code returns to 0, all real outputs VSS, `done`=1. Then IDLE.
- Mutual exclusion: `precharge`, `wl_en` and `sae` are never VDD in the same cycle. `wl_en` is VDD only while a nonzero code is driven.
- Request flow: `req_ready` is 0 in every state except IDLE. Requests presented while busy are not consumed.
- All outputs are registered; real outputs are derived only from registered logic.

## Timing
- Handshake completes at edge 0, i.e. `req_valid && req_ready` sampled high.
- With defaults, a write has PRE in cycles 1–2, SETUP in 3, ACC in 4–6, and REL/`done` in 7.
- A read adds SENSE in cycle 7 and moves REL/`done` to cycle 8.
- General `done` latency after the handshake:
  - Write: PRE_CYC+WL_CYC+2 cycles.
  - Read: PRE_CYC+WL_CYC+3 cycles.
- `req_ready` returns to 1 in the cycle after `done`. Back-to-back requests therefore have a one-cycle IDLE gap.
- Reset:
  - Asserting `rst_n` low forces IDLE immediately, without waiting for `clk`.
  - All real outputs go to VSS and `row_sel` to code 0; `done`, `err` and `req_ready` go to 0.
  - `req_ready` rises on the first edge after release.
  - A reset mid-access produces no `done`.
- Phase counter: one counter, loaded at each phase entry with length-1 and counted down to 0. Width is `$clog2(max(PRE_CYC,WL_CYC))+1`.

## Structure
- Shared package `sram_pkg` holds:
  - `VDD`, `VSS` and `VTH` (0.8).
  - The FSM state enum `acc_state_t`.
  - A function `lvl(logic)` returning VDD/VSS, shared with the decoder and array models.
- One sub-module, `sram_lvl_drv`, parameterised by width: converts a logic vector to a real array via `lvl`. It is used for the `row_sel` bus and the three control levels.

## Test plan
- Reset, then write to addr 5 with defaults:
  - `row_sel` code 6 (bits 1,2 at 1.5, others 0.0) from cycle 3 to cycle 6.
  - `wl_en` 1.5 in cycles 4–6.
  - `done` in cycle 7.
  - `sae` never 1.5.
- Read addr 0:
  - Code 1 driven.
  - `sae`=1.5 only in cycle 7.
  - `done` in cycle 8.
  - `precharge` 1.5 only in cycles 1–2.
- Request addr 15 (ROWS=16):
  - `err` pulses one cycle.
  - `req_ready` stays 1.
  - All real outputs remain 0.0.
- `req_valid` held high with alternating addrs 3/4:
  - Each request is accepted only in IDLE, with one idle cycle between `done` and the next acceptance.
  - No request is lost or duplicated.
- `rst_n` low in cycle 5 of a read:
  - All real outputs 0.0 immediately, before the next edge.
  - No `done`.
  - `req_ready`=1 on the first edge after release.
- PRE_CYC=1, WL_CYC=1, write addr 14:
  - Code 15 driven.
  - `done` at cycle 4.
  - Assertion checks that the three control levels are never simultaneously VDD.
